// File: rtl/matmul_addr_gen.sv
// Address generator for an M x N x K matrix-multiply traversal (i outer, j, k inner).
// Emits one word address per ready/valid beat for the A, B, B-transposed or C operand.
module matmul_addr_gen #(
  parameter  int M    = 3,
  parameter  int N    = 3,
  parameter  int K    = 3,
  localparam int MK   = M * K,
  localparam int KN   = K * N,
  localparam int MN   = M * N,
  localparam int MAXP = ((MK > KN ? MK : KN) > MN) ? (MK > KN ? MK : KN) : MN,
  localparam int AW   = (MAXP > 1) ? $clog2(MAXP) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          abort,
  input  logic          ready,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [IW-1:0] IMAX  = IW'(M - 1);
  localparam logic [JW-1:0] JMAX  = JW'(N - 1);
  localparam logic [KW-1:0] KMAX  = KW'(K - 1);
  localparam logic [AW-1:0] KSTEP = AW'(K);
  localparam logic [AW-1:0] NSTEP = AW'(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] iK_q, iK_d;
  logic [AW-1:0] iN_q, iN_d;
  logic [AW-1:0] jK_q, jK_d;
  logic [AW-1:0] kN_q, kN_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_q, last_d;

  // The products i*K, i*N, j*K and k*N are kept as running sums that step by K or N
  // whenever their counter advances, so the address is a registered add of two terms.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    iK_d    = iK_q;
    iN_d    = iN_q;
    jK_d    = jK_q;
    kN_d    = kN_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          iK_d    = '0;
          iN_d    = '0;
          jK_d    = '0;
          kN_d    = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
        end else if (ready) begin
          if (last_q) begin
            state_d = DONE;
          end else if (k_q != KMAX) begin
            k_d  = k_q + 1'b1;
            kN_d = kN_q + NSTEP;
          end else begin
            k_d  = '0;
            kN_d = '0;
            if (j_q != JMAX) begin
              j_d  = j_q + 1'b1;
              jK_d = jK_q + KSTEP;
            end else begin
              j_d  = '0;
              jK_d = '0;
              i_d  = i_q + 1'b1;
              iK_d = iK_q + KSTEP;
              iN_d = iN_q + NSTEP;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        iK_d    = '0;
        iN_d    = '0;
        jK_d    = '0;
        kN_d    = '0;
      end
      default: state_d = IDLE;
    endcase

    case (mode_d)
      2'd0:    addr_d = iK_d + AW'(k_d);
      2'd1:    addr_d = kN_d + AW'(j_d);
      2'd2:    addr_d = jK_d + AW'(k_d);
      default: addr_d = iN_d + AW'(j_d);
    endcase

    last_d = (i_d == IMAX) && (j_d == JMAX) && (k_d == KMAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      iK_q    <= '0;
      iN_q    <= '0;
      jK_q    <= '0;
      kN_q    <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      iK_q    <= iK_d;
      iN_q    <= iN_d;
      jK_q    <= jK_d;
      kN_q    <= kN_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  // last_q tracks the counters even when idle, so it only reaches the port with valid.
  assign valid = (state_q == RUN);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign addr  = addr_q;
  assign last  = last_q & valid;

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Scoreboard bench for matmul_addr_gen: the driver queues expected beats from an
// index-arithmetic model, the monitor pops and compares on every accepted beat.
module tb_matmul_addr_gen;

  localparam int MP    = 3;
  localparam int NP    = 3;
  localparam int KP    = 3;
  localparam int BEATS = MP * NP * KP;
  localparam int AWP   = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [1:0]     mode;
  logic           abort;
  logic           ready;
  logic           valid;
  logic [AWP-1:0] addr;
  logic           last;
  logic           busy;
  logic           done;

  logic           start1;
  logic [1:0]     mode1;
  logic           abort1;
  logic           ready1;
  logic           valid1;
  logic [0:0]     addr1;
  logic           last1;
  logic           busy1;
  logic           done1;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int sbQ[$];

  bit             holdPending = 1'b0;
  logic [AWP-1:0] holdAddr;
  logic           holdLast;

  matmul_addr_gen #(.M(MP), .N(NP), .K(KP)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .abort (abort),
    .ready (ready),
    .valid (valid),
    .addr  (addr),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  matmul_addr_gen #(.M(1), .N(1), .K(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .mode  (mode1),
    .abort (abort1),
    .ready (ready1),
    .valid (valid1),
    .addr  (addr1),
    .last  (last1),
    .busy  (busy1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: decompose the beat index into (i, j, k) and apply the mode formula.
  function automatic int expAddr(input int md, input int beat);
    int i, j, k;
    i = beat / (NP * KP);
    j = (beat / KP) % NP;
    k = beat % KP;
    case (md)
      0:       return i * KP + k;
      1:       return k * NP + j;
      2:       return j * KP + k;
      default: return i * NP + j;
    endcase
  endfunction

  // Monitor: compares every accepted beat against the queue and checks hold stability.
  always @(negedge clk) begin
    if (!rst) begin
      holdPending = 1'b0;
    end else begin
      if (valid) checkOutput("validOnlyInRun", busy, 1);
      if (holdPending) begin
        checkOutput("holdValid", valid, 1);
        checkOutput("holdAddr", addr, holdAddr);
        checkOutput("holdLast", last, holdLast);
      end
      if (valid && ready && !abort) begin
        beats++;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedBeat: got addr %0d, expected no beat", addr);
        end else begin
          int e;
          e = sbQ.pop_front();
          checkOutput("beatAddr", addr, e / 2);
          checkOutput("beatLast", last, e % 2);
        end
      end
      holdPending = valid && !ready && !abort;
      holdAddr    = addr;
      holdLast    = last;
    end
  end

  // readyKind: 0 always high, 1 repeating 1,0,0,1, 2 random.
  task automatic applyStimulus(input int md, input int readyKind, input int abortBeat,
                               input bit midStart, input bit midReset);
    int  cyc;
    int  base;
    bit  finished;
    bit  aborted;
    bit  resetHit;
    cyc      = 0;
    finished = 1'b0;
    aborted  = 1'b0;
    resetHit = 1'b0;
    base     = beats;
    start    = 1'b1;
    mode     = 2'(md);
    for (int b = 0; b < BEATS; b++)
      sbQ.push_back(expAddr(md, b) * 2 + ((b == BEATS - 1) ? 1 : 0));
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 2'($urandom);
    checkOutput("startLatency", valid, 1);
    while (!finished && cyc < 400) begin
      case (readyKind)
        0:       ready = 1'b1;
        1:       ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      abort = (abortBeat >= 0) && !aborted && (beats - base == abortBeat);
      start = midStart && (cyc == 10);
      if (midStart && cyc == 10) mode = 2'(3 - md);
      if (midReset && cyc == 8) begin
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rstValid", valid, 0);
        checkOutput("rstAddr", addr, 0);
        checkOutput("rstLast", last, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        sbQ.delete();
        @(posedge clk); #3;
        rst = 1'b1;
        resetHit = 1'b1;
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (abort) begin
          aborted = 1'b1;
          abort   = 1'b0;
          sbQ.delete();
          checkOutput("abortValid", valid, 0);
        end
        if (done) finished = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!finished) checkOutput("doneTimeout", 0, 1);
    if (resetHit) begin
      checkOutput("postRstBusy", busy, 0);
    end else begin
      checkOutput("donePulse", done, 1);
      checkOutput("doneValid", valid, 0);
      checkOutput("doneBusy", busy, 0);
      checkOutput("beatCount", beats - base, aborted ? abortBeat : BEATS);
      checkOutput("sbDrained", sbQ.size(), 0);
      if (readyKind == 0 && !aborted) checkOutput("noBubbles", cyc, BEATS);
      @(posedge clk); #1;
      checkOutput("doneOneCycle", done, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    mode   = 2'd0;
    abort  = 1'b0;
    ready  = 1'b0;
    start1 = 1'b0;
    mode1  = 2'd0;
    abort1 = 1'b0;
    ready1 = 1'b1;
    #3;
    checkOutput("resetValid", valid, 0);
    checkOutput("resetAddr", addr, 0);
    checkOutput("resetLast", last, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int md = 0; md < 4; md++) applyStimulus(md, 0, -1, 1'b0, 1'b0);
    applyStimulus(0, 1, -1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) applyStimulus(int'($urandom_range(0, 3)), 2, -1, 1'b0, 1'b0);
    applyStimulus(0, 0, 5, 1'b0, 1'b0);
    applyStimulus(0, 0, -1, 1'b0, 1'b0);
    applyStimulus(int'($urandom_range(0, 3)), 2, int'($urandom_range(1, 20)), 1'b0, 1'b0);
    applyStimulus(1, 0, -1, 1'b0, 1'b1);
    applyStimulus(0, 0, -1, 1'b1, 1'b0);
    applyStimulus(2, 1, -1, 1'b1, 1'b0);

    for (int md = 0; md < 4; md++) begin
      start1 = 1'b1;
      mode1  = 2'(md);
      @(posedge clk); #1;
      start1 = 1'b0;
      checkOutput("unitValid", valid1, 1);
      checkOutput("unitAddr", addr1, 0);
      checkOutput("unitLast", last1, 1);
      @(posedge clk); #1;
      checkOutput("unitDoneValid", valid1, 0);
      checkOutput("unitDone", done1, 1);
      checkOutput("unitBusy", busy1, 0);
      @(posedge clk); #1;
      checkOutput("unitDoneOneCycle", done1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
